// File: rtl/m2vstbuf_sched_pkg.sv
// Purpose: shared types and constants for the m2vstbuf bit-access scheduler.
//   Scanner state encodings, start-code prefix bytes, stbuf window widths and
//   the packed stbuf command bundle driven by the scheduler.
package m2vstbuf_sched_pkg;

  localparam int unsigned BUF_W   = 13;  // stbuf window width
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PW_W    = 4;   // parser shift width field
  localparam int unsigned VW_W    = 3;   // VLD shift width field
  localparam int unsigned BURST_W = 8;   // holds VLD_BURST up to 255
  localparam int unsigned ZCNT_W  = 2;

  // Start-code scanner states
  localparam logic [1:0] SC_IDLE  = 2'd0;
  localparam logic [1:0] SC_ALIGN = 2'd1;
  localparam logic [1:0] SC_SCAN  = 2'd2;
  localparam logic [1:0] SC_CODE  = 2'd3;

  // Start-code prefix bytes (00 00 01 xx)
  localparam logic [BYTE_W-1:0] PREFIX_ZERO = 8'h00;
  localparam logic [BYTE_W-1:0] PREFIX_ONE  = 8'h01;

  // Zero-run counter saturates here; longer zero runs are still a valid prefix
  localparam logic [ZCNT_W-1:0] ZCNT_SAT = 2'd2;

  // One cycle's worth of commands to the stbuf shift/align port
  typedef struct packed {
    logic            pshift;
    logic [PW_W-1:0] pwidth;
    logic            palign;
    logic            vshift;
    logic [VW_W-1:0] vwidth;
  } sb_cmd_t;

endpackage

// File: rtl/m2vstbuf_scscan.sv
// Purpose: start-code scanner. Byte-aligns the stream, then consumes bytes
//   until a 00 00 01 prefix, captures the following byte as the start code.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   i_softreset       synchronous clear
//   i_byte            next stream byte (top of stbuf window)
//   i_valid           stbuf window valid
//   i_sc_req/abort    start / cancel a search
//   o_sc_busy         scanner owns the buffer (registered)
//   o_sc_found        one-cycle found pulse (registered)
//   o_sc_code         captured start code (registered)
//   o_palign_c        align strobe this cycle (combinational)
//   o_pshift_c        8-bit shift strobe this cycle (combinational)
module m2vstbuf_scscan
  import m2vstbuf_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_softreset,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_valid,
  input  logic              i_sc_req,
  input  logic              i_sc_abort,
  output logic              o_sc_busy,
  output logic              o_sc_found,
  output logic [BYTE_W-1:0] o_sc_code,
  output logic              o_palign_c,
  output logic              o_pshift_c
);

  logic [1:0]        r_state, w_state_nxt;
  logic [ZCNT_W-1:0] r_zcnt, w_zcnt_nxt;
  logic [BYTE_W-1:0] r_code, w_code_nxt;
  logic              r_busy, r_found, w_found_nxt;

  // Next-state, zero-run tracking and stbuf strobes
  always_comb begin
    w_state_nxt = r_state;
    w_zcnt_nxt  = r_zcnt;
    w_code_nxt  = r_code;
    w_found_nxt = 1'b0;
    o_palign_c  = 1'b0;
    o_pshift_c  = 1'b0;
    if (i_softreset) begin
      w_state_nxt = SC_IDLE;
      w_zcnt_nxt  = '0;
      w_code_nxt  = '0;
    end else if ((r_state != SC_IDLE) && i_sc_abort) begin
      // abort wins over any consume in the same cycle
      w_state_nxt = SC_IDLE;
      w_zcnt_nxt  = '0;
    end else begin
      case (r_state)
        SC_IDLE: begin
          if (i_sc_req) w_state_nxt = SC_ALIGN;
        end
        SC_ALIGN: begin
          if (i_valid) begin
            o_palign_c  = 1'b1;
            w_zcnt_nxt  = '0;
            w_state_nxt = SC_SCAN;
          end
        end
        SC_SCAN: begin
          if (i_valid) begin
            o_pshift_c = 1'b1;
            if (i_byte == PREFIX_ZERO) begin
              w_zcnt_nxt = (r_zcnt == ZCNT_SAT) ? ZCNT_SAT : r_zcnt + ZCNT_W'(1);
            end else if ((i_byte == PREFIX_ONE) && (r_zcnt == ZCNT_SAT)) begin
              w_zcnt_nxt  = '0;
              w_state_nxt = SC_CODE;
            end else begin
              w_zcnt_nxt = '0;
            end
          end
        end
        SC_CODE: begin
          if (i_valid) begin
            o_pshift_c  = 1'b1;
            w_code_nxt  = i_byte;
            w_found_nxt = 1'b1;
            w_state_nxt = SC_IDLE;
          end
        end
        default: w_state_nxt = SC_IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SC_IDLE;
      r_zcnt  <= '0;
      r_code  <= '0;
      r_busy  <= 1'b0;
      r_found <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_zcnt  <= w_zcnt_nxt;
      r_code  <= w_code_nxt;
      r_busy  <= (w_state_nxt != SC_IDLE);
      r_found <= w_found_nxt;
    end
  end

  assign o_sc_busy  = r_busy;
  assign o_sc_found = r_found;
  assign o_sc_code  = r_code;

endmodule

// File: rtl/m2vstbuf_sched.sv
// Purpose: bit-access scheduler sharing the stbuf shift/align port between
//   the start-code scanner, the header parser and the VLD. At most one
//   consume per cycle, only while buffer_valid. Acks and sb_* strobes are
//   zero-latency (same cycle as the stbuf shift).
// Ports:
//   clk, reset_n, softreset          clocking / resets
//   buffer_data, buffer_valid        stbuf window
//   sb_pshift/pwidth/palign          parser shift/align port of stbuf
//   sb_vshift/vwidth                 VLD shift port of stbuf
//   sc_req/abort/busy/found/code     start-code search interface
//   hdr_req/width/align/ack          header parser consume interface
//   vld_req/width/ack                VLD consume interface
module m2vstbuf_sched
  import m2vstbuf_sched_pkg::*;
#(
  parameter int unsigned VLD_BURST = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              softreset,
  input  logic [BUF_W-1:0]  buffer_data,
  input  logic              buffer_valid,
  output logic              sb_pshift,
  output logic [PW_W-1:0]   sb_pwidth,
  output logic              sb_palign,
  output logic              sb_vshift,
  output logic [VW_W-1:0]   sb_vwidth,
  input  logic              sc_req,
  input  logic              sc_abort,
  output logic              sc_busy,
  output logic              sc_found,
  output logic [BYTE_W-1:0] sc_code,
  input  logic              hdr_req,
  input  logic [PW_W-1:0]   hdr_width,
  input  logic              hdr_align,
  output logic              hdr_ack,
  input  logic              vld_req,
  input  logic [VW_W-1:0]   vld_width,
  output logic              vld_ack
);

  sb_cmd_t             w_cmd;
  logic                w_sc_busy, w_sc_palign_c, w_sc_pshift_c;
  logic                w_enable, w_hdr_gnt, w_vld_gnt, w_hdr_shift, w_vld_shift;
  logic                w_unused_tail;
  logic [BURST_W-1:0]  r_burst_cnt;

  // Only the top byte is decoded here; the parser reads the full window itself
  assign w_unused_tail = ^buffer_data[BUF_W-BYTE_W-1:0];

  m2vstbuf_scscan u_scscan (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_softreset(softreset),
    .i_byte     (buffer_data[BUF_W-1 -: BYTE_W]),
    .i_valid    (buffer_valid),
    .i_sc_req   (sc_req),
    .i_sc_abort (sc_abort),
    .o_sc_busy  (w_sc_busy),
    .o_sc_found (sc_found),
    .o_sc_code  (sc_code),
    .o_palign_c (w_sc_palign_c),
    .o_pshift_c (w_sc_pshift_c)
  );

  // Keeps every strobe and ack quiet while either reset is active
  assign w_enable = reset_n && !softreset;

  // Arbitration: scanner > hdr > vld, with vld holding off hdr for a bounded burst
  always_comb begin
    w_hdr_gnt = 1'b0;
    w_vld_gnt = 1'b0;
    if (!w_sc_busy && w_enable && buffer_valid) begin
      if (hdr_req && (!vld_req || (r_burst_cnt >= BURST_W'(VLD_BURST)))) begin
        w_hdr_gnt = 1'b1;
      end else if (vld_req) begin
        w_vld_gnt = 1'b1;
      end
    end
  end

  // Zero width is acknowledged without touching the stream
  assign w_hdr_shift = w_hdr_gnt && !hdr_align && (hdr_width != '0);
  assign w_vld_shift = w_vld_gnt && (vld_width != '0);

  // stbuf command mux
  always_comb begin
    w_cmd = '0;
    if (w_sc_busy) begin
      w_cmd.palign = w_sc_palign_c;
      w_cmd.pshift = w_sc_pshift_c;
      w_cmd.pwidth = w_sc_pshift_c ? PW_W'(BYTE_W) : '0;
    end else begin
      w_cmd.palign = w_hdr_gnt && hdr_align;
      w_cmd.pshift = w_hdr_shift;
      w_cmd.pwidth = w_hdr_shift ? hdr_width : '0;
      w_cmd.vshift = w_vld_shift;
      w_cmd.vwidth = w_vld_shift ? vld_width : '0;
    end
  end

  // Counts vld wins over a waiting hdr request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_burst_cnt <= '0;
    end else if (softreset || !vld_req || w_hdr_gnt) begin
      r_burst_cnt <= '0;
    end else if (w_vld_gnt && hdr_req) begin
      r_burst_cnt <= r_burst_cnt + BURST_W'(1);
    end
  end

  assign sb_pshift = w_cmd.pshift;
  assign sb_pwidth = w_cmd.pwidth;
  assign sb_palign = w_cmd.palign;
  assign sb_vshift = w_cmd.vshift;
  assign sb_vwidth = w_cmd.vwidth;
  assign sc_busy   = w_sc_busy;
  assign hdr_ack   = w_hdr_gnt;
  assign vld_ack   = w_vld_gnt;

endmodule

// File: tb/tb_m2vstbuf_sched.sv
// Testbench for m2vstbuf_sched. The bench plays the stbuf (a byte array with a
// bit pointer moved by the sb_* strobes) and the three requesters.
module tb_m2vstbuf_sched;

  localparam int unsigned VLD_BURST = 2;

  logic        clk;
  logic        reset_n;
  logic        softreset;
  logic [12:0] buffer_data;
  logic        buffer_valid;
  logic        sb_pshift;
  logic [3:0]  sb_pwidth;
  logic        sb_palign;
  logic        sb_vshift;
  logic [2:0]  sb_vwidth;
  logic        sc_req;
  logic        sc_abort;
  logic        sc_busy;
  logic        sc_found;
  logic [7:0]  sc_code;
  logic        hdr_req;
  logic [3:0]  hdr_width;
  logic        hdr_align;
  logic        hdr_ack;
  logic        vld_req;
  logic [2:0]  vld_width;
  logic        vld_ack;

  int checks = 0;
  int errors = 0;

  m2vstbuf_sched #(.VLD_BURST(VLD_BURST)) dut (
    .clk(clk), .reset_n(reset_n), .softreset(softreset),
    .buffer_data(buffer_data), .buffer_valid(buffer_valid),
    .sb_pshift(sb_pshift), .sb_pwidth(sb_pwidth), .sb_palign(sb_palign),
    .sb_vshift(sb_vshift), .sb_vwidth(sb_vwidth),
    .sc_req(sc_req), .sc_abort(sc_abort), .sc_busy(sc_busy),
    .sc_found(sc_found), .sc_code(sc_code),
    .hdr_req(hdr_req), .hdr_width(hdr_width), .hdr_align(hdr_align), .hdr_ack(hdr_ack),
    .vld_req(vld_req), .vld_width(vld_width), .vld_ack(vld_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stbuf model: stream bytes and a bit pointer
  logic [7:0] mem [0:511];
  int         ptr;

  // sampled outputs of the last cycle
  logic       s_pshift, s_palign, s_vshift, s_hack, s_vack, s_busy, s_found;
  logic [3:0] s_pw;
  logic [2:0] s_vw;
  logic [7:0] s_code;

  function automatic logic [12:0] window(input int p);
    logic [12:0] w;
    logic [7:0]  t;
    int          b;
    w = '0;
    for (int k = 0; k < 13; k++) begin
      b = p + k;
      t = mem[b >> 3] << (b & 7);
      w = {w[11:0], t[7]};
    end
    return w;
  endfunction

  task automatic load_stream(input logic [7:0] q[$], input int off);
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    for (int i = 0; i < q.size(); i++) mem[i] = q[i];
    ptr = off;
    buffer_data = window(ptr);
  endtask

  // sample at negedge, apply the consume at posedge, refresh the window
  task automatic tick();
    @(negedge clk);
    s_pshift = sb_pshift; s_pw = sb_pwidth; s_palign = sb_palign;
    s_vshift = sb_vshift; s_vw = sb_vwidth;
    s_hack = hdr_ack; s_vack = vld_ack;
    s_busy = sc_busy; s_found = sc_found; s_code = sc_code;
    @(posedge clk);
    if (s_palign) ptr = ((ptr + 7) / 8) * 8;
    if (s_pshift) ptr = ptr + int'(s_pw);
    if (s_vshift) ptr = ptr + int'(s_vw);
    #1;
    buffer_data = window(ptr);
  endtask

  // reference: first 00 00 01 xx at or after byte 'start'
  function automatic void ref_scan(input logic [7:0] q[$], input int start,
                                   output logic [7:0] code, output int nbytes, output bit ok);
    ok = 0; code = 8'h00; nbytes = 0;
    for (int j = start + 2; j + 1 < q.size(); j++) begin
      if (q[j] == 8'h01 && q[j-1] == 8'h00 && q[j-2] == 8'h00) begin
        code = q[j+1]; nbytes = j + 2 - start; ok = 1;
        return;
      end
    end
  endfunction

  // runs one search to its found pulse and tallies the strobes seen
  task automatic do_scan(input int pct, output int n_found, output logic [7:0] code,
                         output int n_sh8, output int n_al, output int n_other,
                         output bit busy_at_found, output bit found_after);
    n_found = 0; code = 8'h00; n_sh8 = 0; n_al = 0; n_other = 0;
    busy_at_found = 1'b1; found_after = 1'b0;
    sc_req = 1'b1;
    for (int c = 0; c < 600; c++) begin
      buffer_valid = ($urandom_range(99) < 32'(pct));
      tick();
      if (s_busy) sc_req = 1'b0;
      if (s_palign) n_al++;
      if (s_pshift && s_pw == 4'd8) n_sh8++;
      if ((s_pshift && s_pw != 4'd8) || s_vshift || s_hack || s_vack) n_other++;
      if (s_found) begin
        n_found++; code = s_code; busy_at_found = s_busy;
        break;
      end
    end
    sc_req = 1'b0;
    buffer_valid = 1'b1;
    tick();
    found_after = s_found;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; softreset = 1'b0;
    sc_req = 1'b1; sc_abort = 1'b0; hdr_req = 1'b1; hdr_width = 4'd5; hdr_align = 1'b0;
    vld_req = 1'b1; vld_width = 3'd3; buffer_valid = 1'b1;
    load_stream('{8'h00, 8'h00, 8'h01, 8'hB3}, 0);
    tick();
    checks++;
    if ({s_pshift, s_pw, s_palign, s_vshift, s_vw, s_busy, s_found, s_code, s_hack, s_vack} !== 24'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", {s_pshift, s_pw, s_palign, s_vshift, s_vw, s_busy, s_found, s_code, s_hack, s_vack});
    end
    sc_req = 1'b0; hdr_req = 1'b0; vld_req = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++;
    if ({s_pshift, s_pw, s_palign, s_vshift, s_vw, s_busy, s_found, s_code, s_hack, s_vack} !== 24'h0) begin
      errors++;
      $display("FAIL reset_release: got %h expected 0", {s_pshift, s_pw, s_palign, s_vshift, s_vw, s_busy, s_found, s_code, s_hack, s_vack});
    end
  endtask

  task automatic test_scan_directed();
    logic [7:0] q[$];
    logic [7:0] code, ecode;
    int nf, nsh, nal, noth, enb;
    bit baf, fa, ok;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) q = '{8'h12, 8'h00, 8'h00, 8'h01, 8'hB3, 8'h77};
      else if (t == 1) q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hB5, 8'h77};
      else q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h77};
      load_stream(q, 0);
      ref_scan(q, 0, ecode, enb, ok);
      do_scan(100, nf, code, nsh, nal, noth, baf, fa);
      checks++;
      if (nf !== 1 || code !== ecode) begin
        errors++;
        $display("FAIL scan_dir%0d_code: got found=%0d code=%h expected found=1 code=%h", t, nf, code, ecode);
      end
      checks++;
      if (nsh !== enb || nal !== 1 || noth !== 0) begin
        errors++;
        $display("FAIL scan_dir%0d_consume: got shifts=%0d aligns=%0d other=%0d expected %0d/1/0", t, nsh, nal, noth, enb);
      end
      checks++;
      if (baf !== 1'b0 || fa !== 1'b0) begin
        errors++;
        $display("FAIL scan_dir%0d_pulse: got busy_at_found=%0d found_next=%0d expected 0/0", t, baf, fa);
      end
    end
  endtask

  task automatic test_scan_random();
    logic [7:0] q[$];
    logic [7:0] code, ecode;
    int nf, nsh, nal, noth, enb, off, len, r, pct;
    bit baf, fa, ok;
    for (int t = 0; t < 12; t++) begin
      q = {};
      len = 10 + int'($urandom_range(25));
      for (int i = 0; i < len; i++) begin
        r = int'($urandom_range(99));
        if (r < 50) q.push_back(8'h00);
        else if (r < 70) q.push_back(8'h01);
        else q.push_back(8'($urandom_range(255)));
      end
      q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h01);
      q.push_back(8'($urandom_range(255))); q.push_back(8'h5A);
      off = int'($urandom_range(7));
      pct = 50 + int'($urandom_range(50));
      load_stream(q, off);
      ref_scan(q, (off + 7) / 8, ecode, enb, ok);
      do_scan(pct, nf, code, nsh, nal, noth, baf, fa);
      checks++;
      if (nf !== 1 || code !== ecode) begin
        errors++;
        $display("FAIL scan_rnd%0d_code: got found=%0d code=%h expected found=1 code=%h", t, nf, code, ecode);
      end
      checks++;
      if (nsh !== enb || nal !== 1 || noth !== 0 || baf !== 1'b0 || fa !== 1'b0) begin
        errors++;
        $display("FAIL scan_rnd%0d_consume: got shifts=%0d aligns=%0d other=%0d baf=%0d fa=%0d expected %0d/1/0/0/0",
                 t, nsh, nal, noth, baf, fa, enb);
      end
    end
  endtask

  task automatic test_req_held();
    int cyc;
    logic [7:0] got;
    load_stream('{8'h00, 8'h00, 8'h01, 8'hB3, 8'h00, 8'h00, 8'h01, 8'hB5, 8'h11}, 0);
    buffer_valid = 1'b1; sc_req = 1'b1;
    for (int n = 0; n < 2; n++) begin
      cyc = 0; got = 8'h00;
      s_found = 1'b0;
      while (!s_found && cyc < 40) begin tick(); cyc++; end
      got = s_code;
      checks++;
      if (s_found !== 1'b1 || got !== (n == 0 ? 8'hB3 : 8'hB5) || s_busy !== 1'b0) begin
        errors++;
        $display("FAIL held_found%0d: got found=%0d code=%h busy=%0d expected 1/%h/0", n, s_found, got, s_busy, (n == 0 ? 8'hB3 : 8'hB5));
      end
      if (n == 0) begin
        tick();
        checks++;
        if (s_busy !== 1'b1 || s_palign !== 1'b1) begin
          errors++;
          $display("FAIL held_restart: got busy=%0d palign=%0d expected 1/1", s_busy, s_palign);
        end
      end
    end
    sc_req = 1'b0; sc_abort = 1'b1;
    tick();
    sc_abort = 1'b0;
    checks++;
    if (s_palign !== 1'b0 || s_pshift !== 1'b0) begin
      errors++;
      $display("FAIL held_abort_strobe: got palign=%0d pshift=%0d expected 0/0", s_palign, s_pshift);
    end
    tick();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL held_abort_idle: got busy=%0d expected 0", s_busy);
    end
  endtask

  task automatic test_hdr_valid_toggle();
    hdr_req = 1'b1; hdr_width = 4'd13; hdr_align = 1'b0;
    for (int i = 0; i < 3; i++) begin
      buffer_valid = (i != 1);
      tick();
      checks++;
      if ({s_hack, s_pshift, s_pw} !== (i != 1 ? {1'b1, 1'b1, 4'd13} : 6'b0)) begin
        errors++;
        $display("FAIL hdr_toggle%0d: got ack=%0d pshift=%0d pwidth=%0d expected %0d/%0d/%0d",
                 i, s_hack, s_pshift, s_pw, i != 1, i != 1, i != 1 ? 13 : 0);
      end
    end
    hdr_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    string pat;
    pat = "VVHVVH";
    hdr_req = 1'b1; hdr_width = 4'd4; hdr_align = 1'b0;
    vld_req = 1'b1; vld_width = 3'd3; buffer_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({s_hack, s_vack} !== (pat[i] == "H" ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL burst_grant%0d: got hack=%0d vack=%0d expected %s", i, s_hack, s_vack, pat.substr(i, i));
      end
    end
    hdr_req = 1'b0; vld_req = 1'b0;
    tick();
  endtask

  task automatic test_arb_random();
    int streak;
    bit eh, ev, ehs, evs;
    logic [13:0] exp_v, obs_v;
    streak = 0;
    hdr_req = 1'b0; vld_req = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!hdr_req || s_hack) begin
        hdr_req = ($urandom_range(99) < 60);
        hdr_width = 4'($urandom_range(13));
        hdr_align = ($urandom_range(99) < 15);
      end
      if (!vld_req || s_vack) begin
        vld_req = ($urandom_range(99) < 70);
        vld_width = 3'($urandom_range(7));
      end
      buffer_valid = ($urandom_range(99) < 75);
      // vld may win over a waiting hdr at most VLD_BURST times in a row
      eh = buffer_valid && hdr_req && (!vld_req || streak >= int'(VLD_BURST));
      ev = buffer_valid && vld_req && !eh;
      ehs = eh && !hdr_align && hdr_width != 4'd0;
      evs = ev && vld_width != 3'd0;
      exp_v = {eh, ev, eh && hdr_align, ehs, ehs ? hdr_width : 4'd0, evs, evs ? vld_width : 3'd0};
      tick();
      obs_v = {s_hack, s_vack, s_palign, s_pshift, s_pw, s_vshift, s_vw};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL arb_cycle%0d: got %b expected %b", c, obs_v, exp_v);
      end
      if (!vld_req || eh) streak = 0;
      else if (ev && hdr_req) streak++;
    end
    hdr_req = 1'b0; vld_req = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] q[$];
    bit any_found;
    q = {};
    for (int i = 0; i < 40; i++) q.push_back(8'h55);
    load_stream(q, 0);
    any_found = 0;
    buffer_valid = 1'b1; sc_req = 1'b1;
    tick();
    sc_req = 1'b0; hdr_req = 1'b1; hdr_width = 4'd5; hdr_align = 1'b0;
    tick();
    checks++;
    if (s_palign !== 1'b1 || s_hack !== 1'b0 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_align: got palign=%0d hack=%0d busy=%0d expected 1/0/1", s_palign, s_hack, s_busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      any_found |= s_found;
      checks++;
      if (s_pshift !== 1'b1 || s_pw !== 4'd8 || s_hack !== 1'b0) begin
        errors++;
        $display("FAIL abort_scan%0d: got pshift=%0d pwidth=%0d hack=%0d expected 1/8/0", i, s_pshift, s_pw, s_hack);
      end
    end
    sc_abort = 1'b1;
    tick();
    any_found |= s_found;
    sc_abort = 1'b0;
    checks++;
    if ({s_pshift, s_palign, s_hack, s_vack} !== 4'b0) begin
      errors++;
      $display("FAIL abort_cycle: got pshift=%0d palign=%0d hack=%0d vack=%0d expected 0", s_pshift, s_palign, s_hack, s_vack);
    end
    tick();
    any_found |= s_found;
    checks++;
    if (s_busy !== 1'b0 || s_hack !== 1'b1 || s_pshift !== 1'b1 || s_pw !== 4'd5 || any_found) begin
      errors++;
      $display("FAIL abort_after: got busy=%0d hack=%0d pshift=%0d pwidth=%0d found=%0d expected 0/1/1/5/0",
               s_busy, s_hack, s_pshift, s_pw, any_found);
    end
    hdr_req = 1'b0;
    tick();
  endtask

  task automatic test_softreset();
    logic [7:0] q[$];
    logic [7:0] code, ecode;
    int nf, nsh, nal, noth, enb;
    bit baf, fa, ok;
    q = '{8'h00, 8'h00, 8'h01, 8'hB8, 8'h00, 8'h00, 8'h01, 8'hB3, 8'h66};
    load_stream(q, 0);
    buffer_valid = 1'b1; sc_req = 1'b1;
    tick();
    sc_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    softreset = 1'b1; hdr_req = 1'b1; hdr_width = 4'd3; hdr_align = 1'b0;
    tick();
    softreset = 1'b0; hdr_req = 1'b0;
    checks++;
    if ({s_pshift, s_palign, s_vshift, s_hack, s_vack} !== 5'b0 || ptr !== 24) begin
      errors++;
      $display("FAIL srst_cycle: got strobes=%b ptr=%0d expected 0 / 24", {s_pshift, s_palign, s_vshift, s_hack, s_vack}, ptr);
    end
    tick();
    checks++;
    if ({s_busy, s_found, s_code, s_pshift, s_pw, s_palign} !== 16'h0) begin
      errors++;
      $display("FAIL srst_after: got busy=%0d found=%0d code=%h pshift=%0d palign=%0d expected all 0",
               s_busy, s_found, s_code, s_pshift, s_palign);
    end
    ref_scan(q, 3, ecode, enb, ok);
    do_scan(100, nf, code, nsh, nal, noth, baf, fa);
    checks++;
    if (nf !== 1 || code !== ecode || nsh !== enb || nal !== 1) begin
      errors++;
      $display("FAIL srst_rescan: got found=%0d code=%h shifts=%0d aligns=%0d expected 1/%h/%0d/1", nf, code, nsh, nal, ecode, enb);
    end
  endtask

  initial begin
    reset_n = 1'b0; softreset = 1'b0; buffer_data = '0; buffer_valid = 1'b0;
    sc_req = 1'b0; sc_abort = 1'b0; hdr_req = 1'b0; hdr_width = '0; hdr_align = 1'b0;
    vld_req = 1'b0; vld_width = '0; ptr = 0;
    s_hack = 1'b0; s_vack = 1'b0;
    test_reset();
    test_scan_directed();
    test_hdr_valid_toggle();
    test_back_to_back();
    test_arb_random();
    test_abort();
    test_scan_random();
    test_req_held();
    test_softreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
